// File: rtl/clock_enable_gen_if.sv
// Interface between the configuration/consumer side and clock_enable_gen.
//   cfg        : CLK register image [6]=PLLENA [5]=OSCENA [4:3]=OSCM [2:0]=CLKSEL
//   cog_ena    : one-cycle pulse per cog clock period
//   pll_ena    : counter-PLL tick, twice per cog period
//   cog_phase  : cog-rate square wave, high for first half of the period
//   mode_cur   : CLKSEL value currently driving the divider
//   switching  : requested mode not yet in effect
// master drives cfg and consumes the enables; slave is the generator.
interface clock_enable_gen_if;
  logic [6:0] cfg;
  logic       cog_ena;
  logic       pll_ena;
  logic       cog_phase;
  logic [2:0] mode_cur;
  logic       switching;

  modport master (
    output cfg,
    input  cog_ena, pll_ena, cog_phase, mode_cur, switching
  );

  modport slave (
    input  cfg,
    output cog_ena, pll_ena, cog_phase, mode_cur, switching
  );
endinterface

// File: rtl/clock_enable_gen.sv
// Single-clock clock-mode generator. Every Propeller clock mode is produced
// as clock-enable pulses derived from clock_160 by a period counter whose
// divisor follows the selected CLKSEL mode. Mode changes are committed only
// at the end of a full period, so no period is ever truncated or stretched.
// PLL modes are accepted only after PLLENA has been held for PLL_SETTLE cycles.
// Ports:
//   clock_160 : fast reference clock, the only clock
//   nres      : asynchronous active-low reset
//   bus       : clock_enable_gen_if.slave (cfg in; cog_ena, pll_ena,
//               cog_phase, mode_cur, switching out)
module clock_enable_gen #(
  parameter int unsigned BASE_DIV   = 2,
  parameter int unsigned RCFAST_DIV = 16,
  parameter int unsigned RCSLOW_DIV = 8192,
  parameter int unsigned XIN_DIV    = 32,
  parameter int unsigned PLL_SETTLE = 1024,
  parameter int unsigned CNT_W      = 14
) (
  input  logic                clock_160,
  input  logic                nres,
  clock_enable_gen_if.slave   bus
);

  localparam int unsigned SET_W = $clog2(PLL_SETTLE + 1);
  localparam int unsigned DIV_W = CNT_W + 1;

  typedef enum logic [2:0] {
    M_RCFAST = 3'd0,
    M_RCSLOW = 3'd1,
    M_XINPUT = 3'd2,
    M_PLL1   = 3'd3,
    M_PLL2   = 3'd4,
    M_PLL4   = 3'd5,
    M_PLL8   = 3'd6,
    M_PLL16  = 3'd7
  } mode_t;

  // Divisor per mode; all entries are elaboration-time constants.
  function automatic logic [DIV_W-1:0] div_of(input mode_t m);
    case (m)
      M_RCFAST: div_of = DIV_W'(RCFAST_DIV);
      M_RCSLOW: div_of = DIV_W'(RCSLOW_DIV);
      M_XINPUT: div_of = DIV_W'(XIN_DIV);
      M_PLL1:   div_of = DIV_W'(BASE_DIV << 4);
      M_PLL2:   div_of = DIV_W'(BASE_DIV << 3);
      M_PLL4:   div_of = DIV_W'(BASE_DIV << 2);
      M_PLL8:   div_of = DIV_W'(BASE_DIV << 1);
      M_PLL16:  div_of = DIV_W'(BASE_DIV);
      default:  div_of = DIV_W'(RCFAST_DIV);
    endcase
  endfunction

  logic [6:0]       cfg_q;
  logic [SET_W-1:0] settle;
  logic             pll_ok;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  mode_t            mode_cur;

  mode_t            target;
  logic             pll_req;
  logic [DIV_W-1:0] cnt_x;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] last_idx;
  logic [DIV_W-1:0] half_last;
  logic             period_end;
  logic             half_end;

  logic             pllena;
  logic             oscena;
  logic [2:0]       clksel;
  logic             unused_oscm;

  assign pllena      = cfg_q[6];
  assign oscena      = cfg_q[5];
  assign clksel      = cfg_q[2:0];
  assign unused_oscm = ^cfg_q[4:3];

  // Configuration register: every decision uses the registered copy.
  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) begin
      cfg_q <= '0;
    end else begin
      cfg_q <= bus.cfg;
    end
  end

  // PLL settle tracking: settle saturates at PLL_SETTLE; pll_ok follows one
  // cycle after saturation and both drop the cycle after PLLENA goes low.
  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) begin
      settle <= '0;
      pll_ok <= 1'b0;
    end else if (!pllena) begin
      settle <= '0;
      pll_ok <= 1'b0;
    end else begin
      if (settle != SET_W'(PLL_SETTLE)) begin
        settle <= settle + SET_W'(1);
      end
      pll_ok <= (settle == SET_W'(PLL_SETTLE));
    end
  end

  // Target mode decode. A PLL request with both enables high but the PLL
  // not yet settled holds the current mode rather than falling back.
  always_comb begin
    target  = mode_cur;
    pll_req = 1'b0;
    case (clksel)
      3'd0: target = M_RCFAST;
      3'd1: target = M_RCSLOW;
      3'd2: target = oscena ? M_XINPUT : M_RCFAST;
      default: begin
        if (!(pllena && oscena)) begin
          target = M_RCFAST;
        end else begin
          pll_req = 1'b1;
          if (pll_ok) begin
            target = mode_t'(clksel);
          end
        end
      end
    endcase
  end

  // Period decode.
  always_comb begin
    cnt_x      = {1'b0, cnt};
    half       = div >> 1;
    last_idx   = div - DIV_W'(1);
    half_last  = half - DIV_W'(1);
    period_end = (cnt_x == last_idx);
    half_end   = (cnt_x == half_last);
  end

  // Period counter and mode commit. The commit shares the wrap cycle, so
  // the new divisor always starts a fresh period at cnt=0.
  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) begin
      cnt      <= '0;
      div      <= DIV_W'(RCFAST_DIV);
      mode_cur <= M_RCFAST;
    end else if (period_end) begin
      cnt <= '0;
      if (target != mode_cur) begin
        mode_cur <= target;
        div      <= div_of(target);
      end
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    bus.cog_ena   = period_end;
    bus.pll_ena   = period_end || half_end;
    bus.cog_phase = (cnt_x < half);
    bus.mode_cur  = mode_cur;
    bus.switching = (target != mode_cur) || (pll_req && !pll_ok);
  end

endmodule

// File: doc/clock_enable_gen.md
Name: clock_enable_gen

Overview:
- Single-clock successor to the MMCM/BUFGMUX clock-mode selector.
- Derives all Propeller clock modes from the one fast clock as clock-enable pulses, replacing the chained global-buffer muxes.
- Supports every CLKSEL mode, including RCSLOW and XINPUT, with parametrised divide ratios.
- Models PLL settle time and switches modes glitch-free on period boundaries; cog and counter-PLL logic consume its enables.

Parameters:
BASE_DIV, 2, clock_160 cycles per cog period in PLLX16; PLLx8/x4/x2/x1 use BASE_DIV<<1..<<4; must be a power of two, >=2
RCFAST_DIV, 16, cog period in RCFAST mode (power of two, >=2)
RCSLOW_DIV, 8192, cog period in RCSLOW mode (power of two, >=2)
XIN_DIV, 32, cog period in XINPUT mode (power of two, >=2)
PLL_SETTLE, 1024, consecutive cycles PLLENA must be held before any PLL mode is accepted
CNT_W, 14, period counter width; must hold max divisor - 1

Ports:
clock_160  in  1  fast reference clock; the only clock
nres  in  1  asynchronous active-low reset
cfg  in  7  CLK register: [6]=PLLENA [5]=OSCENA [4:3]=OSCM (ignored) [2:0]=CLKSEL
cog_ena  out  1  one-cycle pulse, once per cog clock period
pll_ena  out  1  pulse twice per cog period (counter PLL tick)
cog_phase  out  1  square wave at cog rate; high for first half of period
mode_cur  out  3  effective CLKSEL currently driving the divider
switching  out  1  high while a requested mode differs from mode_cur

Behaviour:
- Reset: asynchronous, active-low; one clock (clock_160).
- On reset: cfg_q=0, cnt=0, div=RCFAST_DIV, mode_cur=000, pll_ok=0, settle=0, cog_ena=0, pll_ena=0, cog_phase=1, switching=0.
- All outputs decode registered state; no cfg-to-output combinational path.
- cfg is registered each cycle into cfg_q; all decisions use cfg_q (1-cycle latency).
- Target decode from cfg_q:
  - CLKSEL 000 -> RCFAST; 001 -> RCSLOW.
  - 010 -> XINPUT if OSCENA, else RCFAST.
  - 011..111 -> PLLx1..x16 if PLLENA & OSCENA & pll_ok, else hold mode_cur.
  - If PLLENA or OSCENA is low and the target is a PLL mode, fall back to RCFAST.
- pll_ok / settle counter:
  - settle increments while cfg_q[6]=1, saturating at PLL_SETTLE.
  - pll_ok=1 once settle==PLL_SETTLE.
  - cfg_q[6]=0 clears settle and pll_ok in the next cycle.
- Period counter:
  - cnt runs 0..div-1 and wraps to 0.
  - cog_ena=1 when cnt==div-1.
  - pll_ena=1 when cnt==div-1 or cnt==div/2-1; when div==2, pll_ena=1 every cycle.
  - cog_phase=1 while cnt<div/2.
- Switching:
  - switching=1 whenever target!=mode_cur, or a PLL mode is requested but pll_ok=0.
  - A change commits only in the cog_ena cycle: the next cycle has mode_cur=target, div=new divisor, cnt=0.
  - The old period always completes fully; no truncated or stretched period (aside from the deliberate hold while waiting for pll_ok).
- Simultaneous/rapid events:
  - cfg changes again before commit: the newest target wins; no intermediate mode is applied.
  - PLLENA drops while in a PLL mode: target becomes RCFAST; commit at the next period end.
  - PLLENA drops mid-settle: settle restarts from 0 when it is raised again.
- Divisor table is computed from parameters at elaboration; no runtime multiply.
- Reset mid-period: immediate return to the reset state; the first cog_ena comes RCFAST_DIV cycles after nres deasserts.

Test Plan:
- Reset release, cfg=0000000 -> cog_ena every 16 cycles, pll_ena every 8 cycles, mode_cur=000, switching=0.
- cfg=1101111 from RCFAST -> switching=1 and period stays 16 for 1024+ cycles; then commit at the next cog_ena boundary; period becomes 2, pll_ena every cycle, mode_cur=111.
- PLLx16 running, cfg->1101011 -> current 2-cycle period completes, then period 32, mode_cur=011.
- cfg=1100110 held 500 cycles, then PLLENA=0 for 1 cycle, then 1 again -> no switch before 1024 cycles after re-raise; period stays 16 throughout.
- cfg=0000001 -> after the current period ends, cog_ena every 8192 cycles and cog_phase high for 4096 cycles.
- nres asserted at cnt=5 in PLLx1 -> outputs take reset values immediately; the first cog_ena comes 16 cycles after release.
